// File: rtl/jk_pkg.sv
// Shared types for the JK excitation driver: issued command encoding, FSM states
// and the excitation-table lookup used to turn a desired Q into a J/K pair.
package jk_pkg;

  // Encoded directly as {j, k} so a command can be driven onto the pins as-is.
  typedef enum logic [1:0] {
    HOLD = 2'b00,
    RST  = 2'b01,
    SET  = 2'b10,
    TOG  = 2'b11
  } jk_cmd_e;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_RUN  = 2'd1,
    S_ERR  = 2'd2
  } jk_state_e;

  // policy=0 resolves don't-cares towards hold/set/reset, policy=1 towards toggle.
  function automatic jk_cmd_e jk_excite(input logic qm, input logic t, input logic policy);
    jk_cmd_e cmd;
    if (policy) begin
      if (qm != t) cmd = TOG;
      else         cmd = t ? SET : RST;
    end else begin
      if (qm == t) cmd = HOLD;
      else         cmd = t ? SET : RST;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/jk_target_fifo.sv
// Small 1-bit-wide FIFO holding pending target Q values; pointers carry one
// extra wrap bit so full and empty are told apart without an occupancy counter.
module jk_target_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] mem_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  // A push into a full FIFO is refused even when a pop frees a slot this cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign data_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
  assign rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage has no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives an external JK flip-flop from a stream of desired Q values, checks the
// returned Q two edges after each command and counts issued commands by type.
module jk_excitation_driver
  import jk_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DC_POLICY = 0,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          RESET,
  input  logic          tgt_valid,
  input  logic          tgt_bit,
  output logic          tgt_ready,
  output logic          j,
  output logic          k,
  input  logic          q_fb,
  output logic          busy,
  output logic          err,
  input  logic          clr_err,
  output logic [CW-1:0] cnt_set,
  output logic [CW-1:0] cnt_rst,
  output logic [CW-1:0] cnt_tog,
  output logic [CW-1:0] cnt_hold
);

  localparam logic POLICY = (DC_POLICY != 0);

  jk_state_e     state_q;
  logic          j_q, k_q;
  logic          qm_q;
  logic          err_q;
  logic          chk_v1_q, chk_v2_q;
  logic          chk_exp1_q, chk_exp2_q;
  logic [CW-1:0] cnt_set_q, cnt_rst_q, cnt_tog_q, cnt_hold_q;
  logic [CW-1:0] cnt_set_d, cnt_rst_d, cnt_tog_d, cnt_hold_d;

  logic    fifo_full, fifo_empty, fifo_head;
  logic    push, pop, mismatch;
  jk_cmd_e cmd;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  jk_target_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst_n  (RESET),
    .push_i (push),
    .data_i (tgt_bit),
    .pop_i  (pop),
    .data_o (fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign push     = tgt_valid & ~fifo_full;
  // A detected mismatch freezes the queue so the failing context stays inspectable.
  assign mismatch = chk_v2_q & (q_fb != chk_exp2_q);
  assign pop      = (state_q == S_RUN) & ~fifo_empty & ~mismatch;
  assign cmd      = jk_excite(qm_q, fifo_head, POLICY);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      state_q    <= S_INIT;
      j_q        <= 1'b0;
      k_q        <= 1'b1;
      qm_q       <= 1'b0;
      err_q      <= 1'b0;
      chk_v1_q   <= 1'b0;
      chk_v2_q   <= 1'b0;
      chk_exp1_q <= 1'b0;
      chk_exp2_q <= 1'b0;
    end else begin
      chk_v2_q   <= chk_v1_q;
      chk_exp2_q <= chk_exp1_q;
      chk_v1_q   <= 1'b0;
      unique case (state_q)
        S_INIT: begin
          j_q     <= 1'b0;
          k_q     <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          if (mismatch) begin
            {j_q, k_q} <= HOLD;
            err_q      <= 1'b1;
            chk_v1_q   <= 1'b0;
            chk_v2_q   <= 1'b0;
            state_q    <= S_ERR;
          end else if (pop) begin
            {j_q, k_q} <= cmd;
            qm_q       <= fifo_head;
            chk_v1_q   <= 1'b1;
            chk_exp1_q <= fifo_head;
          end else begin
            {j_q, k_q} <= HOLD;
          end
        end
        S_ERR: begin
          chk_v2_q <= 1'b0;
          if (clr_err) begin
            // Re-force the flip-flop to 0 so the model and the device agree again.
            j_q     <= 1'b0;
            k_q     <= 1'b1;
            qm_q    <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_INIT;
          end else begin
            {j_q, k_q} <= HOLD;
          end
        end
        default: begin
          j_q     <= 1'b0;
          k_q     <= 1'b1;
          qm_q    <= 1'b0;
          state_q <= S_INIT;
        end
      endcase
    end
  end

  // Counters follow the issued J/K pair, not the underlying Q transition.
  always_comb begin
    // NOTE: defaults first so no path leaves a next-state value unassigned.
    cnt_set_d  = cnt_set_q;
    cnt_rst_d  = cnt_rst_q;
    cnt_tog_d  = cnt_tog_q;
    cnt_hold_d = cnt_hold_q;
    if (pop) begin
      unique case (cmd)
        SET:     cnt_set_d  = sat_inc(cnt_set_q);
        RST:     cnt_rst_d  = sat_inc(cnt_rst_q);
        TOG:     cnt_tog_d  = sat_inc(cnt_tog_q);
        default: cnt_hold_d = sat_inc(cnt_hold_q);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      cnt_set_q  <= '0;
      cnt_rst_q  <= '0;
      cnt_tog_q  <= '0;
      cnt_hold_q <= '0;
    end else begin
      cnt_set_q  <= cnt_set_d;
      cnt_rst_q  <= cnt_rst_d;
      cnt_tog_q  <= cnt_tog_d;
      cnt_hold_q <= cnt_hold_d;
    end
  end

  assign tgt_ready = ~fifo_full;
  assign j         = j_q;
  assign k         = k_q;
  assign err       = err_q;
  assign busy      = ~fifo_empty | chk_v1_q | chk_v2_q;
  assign cnt_set   = cnt_set_q;
  assign cnt_rst   = cnt_rst_q;
  assign cnt_tog   = cnt_tog_q;
  assign cnt_hold  = cnt_hold_q;

endmodule
